// File: rtl/cc_reorder_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : cc_reorder_scheduler
// Purpose  : Sits between the cache tag-compare stage and the data reorder
//            path. It accepts one lookup result per valid/ready handshake.
//            A hit writes flag=1 and the hit line into the hit flag/data
//            FIFOs. A miss writes flag=0 and issues one AXI AR burst (8 x 64b,
//            WRAP, critical word first). Lookups are throttled on FIFO
//            almost-full and on the outstanding-miss limit.
// Ports    : clk, rst_n (synchronous, active-low)
//            lookup_*        : lookup result handshake and payload
//            hit_flag_fifo_* : flag FIFO write port and almost-full input
//            hit_data_fifo_* : data FIFO write port and almost-full input
//            mem_ar*         : AXI read-address channel master
//            mem_r*          : R-channel monitor (rlast handshakes retire misses)
//            outstanding_o   : misses with AR accepted but R burst not finished
// Options  : `define CC_SCHED_PERF_CNT_EN adds perf_hit_cnt_o/perf_miss_cnt_o
// Revision : 1.0 - initial release
// ============================================================================
module cc_reorder_scheduler #(
   parameter int MAX_OUTSTANDING = 4,
   parameter int CNT_W           = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             lookup_valid_i,
   output logic             lookup_ready_o,
   input  logic             lookup_hit_i,
   input  logic [31:0]      lookup_addr_i,
   input  logic [517:0]     lookup_data_i,
   input  logic             hit_flag_fifo_afull_i,
   output logic             hit_flag_fifo_wren_o,
   output logic             hit_flag_fifo_wdata_o,
   input  logic             hit_data_fifo_afull_i,
   output logic             hit_data_fifo_wren_o,
   output logic [517:0]     hit_data_fifo_wdata_o,
   output logic [31:0]      mem_araddr_o,
   output logic [3:0]       mem_arlen_o,
   output logic [2:0]       mem_arsize_o,
   output logic [1:0]       mem_arburst_o,
   output logic             mem_arvalid_o,
   input  logic             mem_arready_i,
   input  logic             mem_rvalid_i,
   input  logic             mem_rready_i,
   input  logic             mem_rlast_i,
   output logic [CNT_W-1:0] outstanding_o
`ifdef CC_SCHED_PERF_CNT_EN
   ,
   output logic [31:0]      perf_hit_cnt_o,
   output logic [31:0]      perf_miss_cnt_o
`endif
);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_AR_REQ = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

   state_t             state_q, state_d;
   logic               ready_en_q, ready_en_d;
   logic               flag_wren_q, flag_wren_d;
   logic               flag_wdata_q, flag_wdata_d;
   logic               data_wren_q, data_wren_d;
   logic [517:0]       data_wdata_q, data_wdata_d;
   logic               arvalid_q, arvalid_d;
   logic [31:0]        araddr_q, araddr_d;
   logic [CNT_W-1:0]   outstanding_q, outstanding_d;

   logic               accept;
   logic               ar_hs;
   logic               rlast_hs;

   // ready_en_q keeps the lookup port closed for the first cycle after reset;
   // rst_n in the term keeps it closed while reset is held.
   assign lookup_ready_o = rst_n & ready_en_q & (state_q == ST_IDLE) & ~hit_flag_fifo_afull_i &
                           (lookup_hit_i ? ~hit_data_fifo_afull_i : (outstanding_q < MAX_CNT));

   assign accept   = lookup_valid_i & lookup_ready_o;
   assign ar_hs    = (state_q == ST_AR_REQ) & arvalid_q & mem_arready_i;
   // A stray rlast with nothing outstanding is dropped so the count cannot underflow.
   assign rlast_hs = mem_rvalid_i & mem_rready_i & mem_rlast_i & (outstanding_q != '0);

   always_comb begin
      state_d       = state_q;
      ready_en_d    = 1'b1;
      flag_wren_d   = accept;
      flag_wdata_d  = flag_wdata_q;
      data_wren_d   = accept & lookup_hit_i;
      data_wdata_d  = data_wdata_q;
      arvalid_d     = arvalid_q;
      araddr_d      = araddr_q;
      outstanding_d = outstanding_q;

      if (accept) begin
         flag_wdata_d = lookup_hit_i;
         if (lookup_hit_i) begin
            data_wdata_d = lookup_data_i;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (accept && !lookup_hit_i) begin
               state_d   = ST_AR_REQ;
               arvalid_d = 1'b1;
               // Align to the 64-bit beat; WRAP burst returns the critical word first.
               araddr_d  = lookup_addr_i & 32'hFFFF_FFF8;
            end
         end
         ST_AR_REQ: begin
            if (mem_arready_i) begin
               state_d   = ST_IDLE;
               arvalid_d = 1'b0;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            arvalid_d = 1'b0;
         end
      endcase

      // Simultaneous issue and retire leave the count unchanged.
      if (ar_hs && !rlast_hs) begin
         outstanding_d = outstanding_q + CNT_W'(1);
      end else if (!ar_hs && rlast_hs) begin
         outstanding_d = outstanding_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         ready_en_q    <= 1'b0;
         flag_wren_q   <= 1'b0;
         flag_wdata_q  <= 1'b0;
         data_wren_q   <= 1'b0;
         data_wdata_q  <= '0;
         arvalid_q     <= 1'b0;
         araddr_q      <= '0;
         outstanding_q <= '0;
      end else begin
         state_q       <= state_d;
         ready_en_q    <= ready_en_d;
         flag_wren_q   <= flag_wren_d;
         flag_wdata_q  <= flag_wdata_d;
         data_wren_q   <= data_wren_d;
         data_wdata_q  <= data_wdata_d;
         arvalid_q     <= arvalid_d;
         araddr_q      <= araddr_d;
         outstanding_q <= outstanding_d;
      end
   end

   assign hit_flag_fifo_wren_o  = flag_wren_q;
   assign hit_flag_fifo_wdata_o = flag_wdata_q;
   assign hit_data_fifo_wren_o  = data_wren_q;
   assign hit_data_fifo_wdata_o = data_wdata_q;
   assign mem_arvalid_o         = arvalid_q;
   assign mem_araddr_o          = araddr_q;
   assign mem_arlen_o           = 4'd7;
   assign mem_arsize_o          = 3'b011;
   assign mem_arburst_o         = 2'b10;
   assign outstanding_o         = outstanding_q;

`ifdef CC_SCHED_PERF_CNT_EN
   logic [31:0] perf_hit_cnt_q, perf_hit_cnt_d;
   logic [31:0] perf_miss_cnt_q, perf_miss_cnt_d;

   // Registered on accept so the count moves together with the flag write.
   always_comb begin
      perf_hit_cnt_d  = perf_hit_cnt_q;
      perf_miss_cnt_d = perf_miss_cnt_q;
      if (accept) begin
         if (lookup_hit_i) begin
            perf_hit_cnt_d = perf_hit_cnt_q + 32'd1;
         end else begin
            perf_miss_cnt_d = perf_miss_cnt_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_hit_cnt_q  <= '0;
         perf_miss_cnt_q <= '0;
      end else begin
         perf_hit_cnt_q  <= perf_hit_cnt_d;
         perf_miss_cnt_q <= perf_miss_cnt_d;
      end
   end

   assign perf_hit_cnt_o  = perf_hit_cnt_q;
   assign perf_miss_cnt_o = perf_miss_cnt_q;
`else
   // Performance counters not built.
`endif

endmodule
`default_nettype wire
